// File: rtl/seg_scan.sv
// seg_scan: time-multiplexed scan driver for an N-digit common-anode
// 7-segment bank. It presents one nibble per scan slot to a downstream
// registered hex-to-segment decoder and drives active-low digit selects
// and the decimal point. Display data is double-buffered: load writes the
// pending bank, and the active bank is refreshed only at frame boundaries.
//
// Each slot is DIV cycles long. The first BLANK cycles keep every select
// off, which covers the decoder's one-cycle latency and avoids ghosting.
// The remaining cycles select the slot's digit if it is visible. The
// per-slot BLANK/SHOW sequencing is carried entirely by the prescaler
// count, so there is no separate state register.
//
// All outputs are registered. The next-cycle values are computed from the
// next prescaler/index/active-bank values, so an output register always
// matches the slot and phase that the counters hold in the same cycle.

module seg_scan #(
    parameter int N_DIGITS = 8,
    parameter int DIV      = 50000,
    parameter int BLANK    = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [4*N_DIGITS-1:0] data_in,
    input  logic [N_DIGITS-1:0]   en_in,
    input  logic [N_DIGITS-1:0]   dp_in,
    input  logic                  lzs,
    output logic [3:0]            digit,
    output logic [N_DIGITS-1:0]   sel_n,
    output logic                  dp_n,
    output logic                  frame_start
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    localparam logic [CW-1:0] CNT_ZERO  = CW'(0);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] CNT_LAST  = CW'(DIV - 1);
    localparam logic [CW-1:0] CNT_SHOW  = CW'(BLANK);
    localparam logic [IW-1:0] IDX_ZERO  = IW'(0);
    localparam logic [IW-1:0] IDX_ONE   = IW'(1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(N_DIGITS - 1);

    // Returns 1 when every nibble at position pos and above is zero.
    // Disabled digits are included on purpose: their stored value still
    // counts toward leading-zero suppression.
    function automatic logic upper_zero(
        input logic [4*N_DIGITS-1:0] data,
        input logic [IW-1:0]         pos
    );
        logic z;
        z = 1'b1;
        for (int k = 0; k < N_DIGITS; k++) begin
            z = z & ((k < int'(pos)) | (data[4*k +: 4] == 4'h0));
        end
        return z;
    endfunction

    // Prescaler and slot index state.
    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_s;
    logic [IW-1:0] idx_r;
    logic [IW-1:0] idx_s;
    logic          tick_s;
    logic          wrap_s;

    // Pending (written by load) and active (displayed) banks.
    logic [4*N_DIGITS-1:0] pend_data_r;
    logic [N_DIGITS-1:0]   pend_en_r;
    logic [N_DIGITS-1:0]   pend_dp_r;
    logic [4*N_DIGITS-1:0] act_data_r;
    logic [N_DIGITS-1:0]   act_en_r;
    logic [N_DIGITS-1:0]   act_dp_r;
    logic [4*N_DIGITS-1:0] act_data_s;
    logic [N_DIGITS-1:0]   act_en_s;
    logic [N_DIGITS-1:0]   act_dp_s;

    // Output registers and their next values.
    logic [3:0]          digit_r;
    logic [N_DIGITS-1:0] sel_n_r;
    logic                dp_n_r;
    logic                frame_start_r;
    logic [3:0]          digit_s;
    logic [N_DIGITS-1:0] sel_n_s;
    logic                dp_n_s;
    logic                frame_start_s;
    logic                show_s;
    logic                suppress_s;
    logic                visible_s;

    // Next prescaler count, slot index, and frame-wrap detection.
    always_comb begin
        cnt_s  = cnt_r;
        idx_s  = idx_r;
        tick_s = (cnt_r == CNT_LAST);
        wrap_s = 1'b0;
        if (tick_s) begin
            cnt_s = CNT_ZERO;
            if (idx_r == IDX_LAST) begin
                idx_s  = IDX_ZERO;
                wrap_s = 1'b1;
            end else begin
                idx_s = idx_r + IDX_ONE;
            end
        end else begin
            cnt_s = cnt_r + CNT_ONE;
        end
    end

    // Next active bank: copy the pending bank at the frame wrap only.
    always_comb begin
        act_data_s = act_data_r;
        act_en_s   = act_en_r;
        act_dp_s   = act_dp_r;
        if (wrap_s) begin
            act_data_s = pend_data_r;
            act_en_s   = pend_en_r;
            act_dp_s   = pend_dp_r;
        end else begin
            act_data_s = act_data_r;
            act_en_s   = act_en_r;
            act_dp_s   = act_dp_r;
        end
    end

    // Next output values for the slot and phase the counters enter next.
    always_comb begin
        digit_s       = act_data_s[4*idx_s +: 4];
        sel_n_s       = {N_DIGITS{1'b1}};
        dp_n_s        = 1'b1;
        frame_start_s = wrap_s;
        show_s        = (cnt_s >= CNT_SHOW);
        suppress_s    = lzs & (idx_s != IDX_ZERO) & upper_zero(act_data_s, idx_s);
        visible_s     = act_en_s[idx_s] & ~suppress_s;
        if (show_s && visible_s) begin
            sel_n_s[idx_s] = 1'b0;
            dp_n_s         = ~act_dp_s[idx_s];
        end else begin
            sel_n_s = {N_DIGITS{1'b1}};
            dp_n_s  = 1'b1;
        end
    end

    // Prescaler, slot index and active bank registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_r      <= CNT_ZERO;
            idx_r      <= IDX_ZERO;
            act_data_r <= {(4*N_DIGITS){1'b0}};
            act_en_r   <= {N_DIGITS{1'b1}};
            act_dp_r   <= {N_DIGITS{1'b0}};
        end else begin
            cnt_r      <= cnt_s;
            idx_r      <= idx_s;
            act_data_r <= act_data_s;
            act_en_r   <= act_en_s;
            act_dp_r   <= act_dp_s;
        end
    end

    // Pending bank capture; the swap reads the value held before this edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend_data_r <= {(4*N_DIGITS){1'b0}};
            pend_en_r   <= {N_DIGITS{1'b1}};
            pend_dp_r   <= {N_DIGITS{1'b0}};
        end else if (load) begin
            pend_data_r <= data_in;
            pend_en_r   <= en_in;
            pend_dp_r   <= dp_in;
        end else begin
            pend_data_r <= pend_data_r;
            pend_en_r   <= pend_en_r;
            pend_dp_r   <= pend_dp_r;
        end
    end

    // Registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            digit_r       <= 4'h0;
            sel_n_r       <= {N_DIGITS{1'b1}};
            dp_n_r        <= 1'b1;
            frame_start_r <= 1'b0;
        end else begin
            digit_r       <= digit_s;
            sel_n_r       <= sel_n_s;
            dp_n_r        <= dp_n_s;
            frame_start_r <= frame_start_s;
        end
    end

    assign digit       = digit_r;
    assign sel_n       = sel_n_r;
    assign dp_n        = dp_n_r;
    assign frame_start = frame_start_r;

endmodule

// File: tb/tb_seg_scan.sv
// Testbench for seg_scan (N_DIGITS=4, DIV=8, BLANK=2). A driver applies
// directed and random stimulus at the falling edge. For each cycle, a
// reference model computes the expected outputs from elapsed time since
// reset and pushes them into a queue. A monitor pops one entry after every
// rising edge and compares it with the DUT outputs.

module tb_seg_scan;

    localparam int N = 4;
    localparam int D = 8;
    localparam int B = 2;
    localparam int FRAME = N * D;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load;
    logic [15:0] data_in;
    logic [3:0]  en_in;
    logic [3:0]  dp_in;
    logic        lzs;
    logic [3:0]  digit;
    logic [3:0]  sel_n;
    logic        dp_n;
    logic        frame_start;

    typedef struct {
        logic [3:0] sel;
        logic [3:0] dig;
        logic       dp;
        logic       fs;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state: cycles since reset, pending and active banks.
    int          t = 0;
    logic [15:0] m_pd = 16'h0;
    logic [15:0] m_ad = 16'h0;
    logic [3:0]  m_pe = 4'hF;
    logic [3:0]  m_ae = 4'hF;
    logic [3:0]  m_pp = 4'h0;
    logic [3:0]  m_ap = 4'h0;
    logic        cur_lzs = 1'b0;

    seg_scan #(.N_DIGITS(N), .DIV(D), .BLANK(B)) dut (
        .clk(clk), .rst_n(rst_n), .load(load), .data_in(data_in),
        .en_in(en_in), .dp_in(dp_in), .lzs(lzs), .digit(digit),
        .sel_n(sel_n), .dp_n(dp_n), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s t=%0d got=%h expected=%h", name, t, act, exp_v);
        end
    endtask

    // One cycle of stimulus plus the model's prediction for after the edge.
    task automatic step(input logic r, input logic ld, input logic [15:0] d,
                        input logic [3:0] e, input logic [3:0] p, input logic z);
        exp_t        x;
        int          idx;
        int          ph;
        logic        vis;
        logic [15:0] upper;
        @(negedge clk);
        rst_n = r; load = ld; data_in = d; en_in = e; dp_in = p; lzs = z;
        if (!r) begin
            t = 0;
            m_pd = 16'h0; m_ad = 16'h0;
            m_pe = 4'hF;  m_ae = 4'hF;
            m_pp = 4'h0;  m_ap = 4'h0;
            x.fs = 1'b0;
        end else begin
            t++;
            x.fs = ((t % FRAME) == 0);
            if (x.fs) begin
                m_ad = m_pd; m_ae = m_pe; m_ap = m_pp;
            end
            if (ld) begin
                m_pd = d; m_pe = e; m_pp = p;
            end
        end
        idx   = (t / D) % N;
        ph    = t % D;
        upper = m_ad >> (4 * idx);
        vis   = m_ae[idx] && !(z && idx != 0 && upper == 16'h0);
        x.dig = upper[3:0];
        x.sel = (ph >= B && vis) ? ~(4'b0001 << idx) : 4'hF;
        x.dp  = (ph >= B && vis) ? ~m_ap[idx] : 1'b1;
        q.push_back(x);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            step(1'b1, 1'b0, 16'($urandom), 4'($urandom), 4'($urandom), cur_lzs);
        end
    endtask

    task automatic idle_until(input int phase);
        for (int i = 0; i < 2 * FRAME; i++) begin
            if ((t % FRAME) == phase) break;
            idle(1);
        end
    endtask

    // Monitor: compare one predicted entry after every rising edge.
    always @(posedge clk) begin
        exp_t m;
        #1;
        if (q.size() > 0) begin
            m = q.pop_front();
            chk("sel_n", sel_n, m.sel);
            chk("digit", digit, m.dig);
            chk("dp_n", {3'b000, dp_n}, {3'b000, m.dp});
            chk("frame_start", {3'b000, frame_start}, {3'b000, m.fs});
        end
    end

    initial begin
        rst_n = 1'b0; load = 1'b0; data_in = 16'h0; en_in = 4'hF; dp_in = 4'h0; lzs = 1'b0;
        // Reset, then idle for more than two frames.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 16'h0, 4'hF, 4'h0, 1'b0);
        idle(80);
        // Load in the middle of a frame.
        idle_until(10);
        step(1'b1, 1'b1, 16'h12AF, 4'hF, 4'b0100, cur_lzs);
        idle(70);
        // Leading-zero suppression.
        cur_lzs = 1'b1;
        step(1'b1, 1'b1, 16'h0050, 4'hF, 4'h0, cur_lzs);
        idle(70);
        step(1'b1, 1'b1, 16'h0000, 4'hF, 4'h0, cur_lzs);
        idle(70);
        cur_lzs = 1'b0;
        // Per-digit enables.
        step(1'b1, 1'b1, 16'h1234, 4'b1010, 4'hF, cur_lzs);
        idle(70);
        // Load on the swap tick.
        step(1'b1, 1'b1, 16'h5555, 4'hF, 4'h1, cur_lzs);
        idle_until(FRAME - 1);
        step(1'b1, 1'b1, 16'h9876, 4'hF, 4'h8, cur_lzs);
        idle(70);
        // Reset in the middle of slot 2.
        idle_until(2 * D + 4);
        step(1'b0, 1'b0, 16'hFFFF, 4'hF, 4'hF, cur_lzs);
        idle(70);
        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 49) == 0) cur_lzs = ~cur_lzs;
            step(($urandom_range(0, 599) != 0), ($urandom_range(0, 7) == 0),
                 16'($urandom), 4'($urandom), 4'($urandom), cur_lzs);
        end
        // Drain with a bounded wait.
        for (int i = 0; i < 10; i++) begin
            if (q.size() == 0) break;
            @(posedge clk);
        end
        #3;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d expected=0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
